// File: rtl/divider_16b.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : divider_16b
// Description : Unsigned 16-bit restoring divider, one quotient bit per cycle.
//               Optional macro DIVIDER_DBZ_EN adds a divide-by-zero fast path
//               and the dbz flag.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DBZ_EN
  ,
  output logic             dbz
`endif
);

  localparam int c_CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [c_CNT_W-1:0] r_count;

  logic [WIDTH:0]     w_shifted;
  logic [WIDTH-1:0]   w_trial;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_borrow;
  logic               w_last;
  logic               w_dbz_hit;

  // Borrow is judged on the full 17-bit shifted value; only the low bits of
  // the difference are ever kept because a non-borrowing trial is < divisor.
  assign w_shifted  = {r_rem, r_dividend[WIDTH-1]};
  assign w_borrow   = (w_shifted < {1'b0, r_divisor});
  assign w_trial    = w_shifted[WIDTH-1:0] - r_divisor;
  assign w_rem_next = w_borrow ? w_shifted[WIDTH-1:0] : w_trial;
  assign w_last     = (r_state == RUN) && (r_count == '0);

`ifdef DIVIDER_DBZ_EN
  assign w_dbz_hit = (b == '0);
`else
  assign w_dbz_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_dbz_hit ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_count == '0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_count    <= '0;
      quotient   <= '0;
      remainder  <= '0;
`ifdef DIVIDER_DBZ_EN
      dbz        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dividend <= a;
            r_divisor  <= b;
            r_rem      <= '0;
            r_quo      <= '0;
            r_count    <= c_CNT_W'(WIDTH - 1);
`ifdef DIVIDER_DBZ_EN
            if (w_dbz_hit) begin
              quotient  <= '1;
              remainder <= a;
              dbz       <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
          r_rem      <= w_rem_next;
          r_quo      <= {r_quo[WIDTH-2:0], ~w_borrow};
          // Counter parks at zero on the final step instead of wrapping.
          if (w_last) begin
            quotient  <= {r_quo[WIDTH-2:0], ~w_borrow};
            remainder <= w_rem_next;
`ifdef DIVIDER_DBZ_EN
            dbz       <= 1'b0;
`endif
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_16b.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for divider_16b: random and directed divisions checked
// against an arithmetic reference model, including latency and busy length.
module tb_divider_16b;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
`ifdef DIVIDER_DBZ_EN
  logic        dbz;
`endif

  divider_16b #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
`ifdef DIVIDER_DBZ_EN
    ,
    .dbz      (dbz)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          done_cyc;
    int          busy_n;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic; k is the cycle in which start is presented.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int k);
    exp_t e;
    e.q        = (y == 0) ? 16'hFFFF : x / y;
    e.r        = (y == 0) ? x : x % y;
    e.z        = 1'b0;
    e.done_cyc = k + 17;
    e.busy_n   = 16;
`ifdef DIVIDER_DBZ_EN
    if (y == 0) begin
      e.z        = 1'b1;
      e.done_cyc = k + 1;
      e.busy_n   = 0;
    end
`endif
    return e;
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input bit expect_it);
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_it) sb.push_back(model(x, y, cyc));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_wait();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", {31'b0, busy | done}, 32'd0);
  endtask

  // Monitor: pops expectations on done, otherwise checks results hold.
  logic [15:0] last_q = '0;
  logic [15:0] last_r = '0;
  logic        last_z = 1'b0;
  int          busy_run = 0;
  bit          armed = 1'b0;
  exp_t        m_e;

  always @(negedge clk) begin
    if (armed) begin
      chk("busy_and_done", {31'b0, busy & done}, 32'd0);
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          m_e = sb.pop_front();
          chk("quotient", {16'b0, quotient}, {16'b0, m_e.q});
          chk("remainder", {16'b0, remainder}, {16'b0, m_e.r});
          chk("done_cycle", cyc, m_e.done_cyc);
          chk("busy_cycles", busy_run, m_e.busy_n);
`ifdef DIVIDER_DBZ_EN
          chk("dbz", {31'b0, dbz}, {31'b0, m_e.z});
`endif
          last_q = m_e.q;
          last_r = m_e.r;
          last_z = m_e.z;
        end
        busy_run = 0;
      end else begin
        chk("quotient_hold", {16'b0, quotient}, {16'b0, last_q});
        chk("remainder_hold", {16'b0, remainder}, {16'b0, last_r});
`ifdef DIVIDER_DBZ_EN
        chk("dbz_hold", {31'b0, dbz}, {31'b0, last_z});
`endif
      end
      if (reset) begin
        last_q   = '0;
        last_r   = '0;
        last_z   = 1'b0;
        busy_run = 0;
      end
    end
  end

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_quotient"}, {16'b0, quotient}, 32'd0);
    chk({tag, "_remainder"}, {16'b0, remainder}, 32'd0);
`ifdef DIVIDER_DBZ_EN
    chk({tag, "_dbz"}, {31'b0, dbz}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [15:0] x, y;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_cleared("reset");
    armed = 1'b1;

    issue(16'd100, 16'd7, 1'b1);
    idle_wait();
    chk("q_100_7", {16'b0, quotient}, 32'd14);
    chk("r_100_7", {16'b0, remainder}, 32'd2);

    issue(16'hFFFF, 16'd1, 1'b1);
    idle_wait();
    chk("q_ffff_1", {16'b0, quotient}, 32'hFFFF);
    chk("r_ffff_1", {16'b0, remainder}, 32'd0);

    issue(16'd5, 16'h1234, 1'b1);
    idle_wait();
    chk("q_5_1234", {16'b0, quotient}, 32'd0);
    chk("r_5_1234", {16'b0, remainder}, 32'd5);

    issue(16'hABCD, 16'd0, 1'b1);
    idle_wait();
    chk("q_div0", {16'b0, quotient}, 32'hFFFF);
    chk("r_div0", {16'b0, remainder}, 32'hABCD);
`ifdef DIVIDER_DBZ_EN
    chk("dbz_div0", {31'b0, dbz}, 32'd1);
`endif

    // Second start during RUN cycle 5 must be ignored.
    issue(16'd1000, 16'd3, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    a = 16'd9; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    idle_wait();
    chk("q_1000_3", {16'b0, quotient}, 32'd333);
    chk("r_1000_3", {16'b0, remainder}, 32'd1);

    // Reset in RUN cycle 8 aborts with no done pulse.
    issue(16'd1000, 16'd7, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_cleared("abort");
    repeat (20) begin @(posedge clk); #1; end
    issue(16'd50, 16'd5, 1'b1);
    idle_wait();
    chk("q_50_5", {16'b0, quotient}, 32'd10);
    chk("r_50_5", {16'b0, remainder}, 32'd0);

    // Start coincident with reset is dropped.
    reset = 1'b1; start = 1'b1; a = 16'd77; b = 16'd7;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk_cleared("rst_start");
    @(posedge clk); #1;
    chk("rst_start_busy2", {31'b0, busy}, 32'd0);

    // Start held high: back-to-back divisions 18 cycles apart.
    k = cyc;
    a = 16'd20; b = 16'd6; start = 1'b1;
    sb.push_back(model(16'd20, 16'd6, k));
    sb.push_back(model(16'd20, 16'd6, k + 18));
    sb.push_back(model(16'd20, 16'd6, k + 36));
    repeat (37) @(posedge clk);
    #1;
    start = 1'b0;
    idle_wait();
    chk("q_20_6", {16'b0, quotient}, 32'd3);
    chk("r_20_6", {16'b0, remainder}, 32'd2);

    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       y = 16'($urandom_range(0, 15));
        1:       y = 16'($urandom);
        2:       y = (x == 16'hFFFF) ? x : x + 16'($urandom_range(1, 100));
        default: y = 16'($urandom_range(1, 255));
      endcase
      issue(x, y, 1'b1);
      idle_wait();
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
